// File: rtl/rvr32_locmem_pkg.sv
// Shared constants and address-decode helpers for the CU-local banked scratchpad.
package rvr32_locmem_pkg;

  localparam int NPORT = 4;
  localparam int NBANK = 4;

  // A strobe pattern with no lanes set marks a read access.
  localparam logic [3:0] WSTRB_RD = 4'b0000;

  typedef logic [1:0] bank_id_t;

  function automatic bank_id_t bank_sel(input logic [31:0] addr);
    return addr[3:2];
  endfunction

  // Caller truncates to the bank row width; bits above it wrap silently.
  function automatic logic [31:0] row_sel(input logic [31:0] addr);
    return addr >> 4;
  endfunction

  function automatic logic is_read(input logic [3:0] wstrb);
    return wstrb == WSTRB_RD;
  endfunction

endpackage

// File: rtl/rvr32_locmem_if.sv
// Bundle of the four CU-local memory request/response ports.
interface rvr32_locmem_if;
  import rvr32_locmem_pkg::*;

  logic [NPORT-1:0][31:0] loc_addr;
  logic [NPORT-1:0][31:0] loc_wdata;
  logic [NPORT-1:0][3:0]  loc_wstrb;
  logic [NPORT-1:0]       loc_valid;
  logic [NPORT-1:0][31:0] loc_rdata;
  logic [NPORT-1:0]       loc_ready;

  modport master (
    output loc_addr, loc_wdata, loc_wstrb, loc_valid,
    input  loc_rdata, loc_ready
  );

  modport slave (
    input  loc_addr, loc_wdata, loc_wstrb, loc_valid,
    output loc_rdata, loc_ready
  );

endinterface

// File: rtl/rvr32_locmem_bank.sv
// Single-port synchronous RAM bank with byte-enable write and registered read.
module rvr32_locmem_bank
  import rvr32_locmem_pkg::*;
#(
  parameter int RW = 8
) (
  input  logic          clk,
  input  logic          en,
  input  logic [RW-1:0] row,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wstrb,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [2**RW];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (is_read(wstrb)) begin
        rdata_q <= mem_q[row];
      end
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) begin
          mem_q[row][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/rvr32_locmem_4p.sv
// Four-port, four-bank word-interleaved CU scratchpad with per-bank round-robin
// arbitration and a saturating bank-conflict counter.
module rvr32_locmem_4p
  import rvr32_locmem_pkg::*;
#(
  parameter int AW    = 10,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  rvr32_locmem_if.slave    loc,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam int RW = AW - 2;

  logic [NPORT-1:0]            elig;
  bank_id_t [NPORT-1:0]        pbank;
  logic [NBANK-1:0][NPORT-1:0] gnt_b;
  logic [NPORT-1:0]            gnt;
  logic [NBANK-1:0][31:0]      bank_rdata;
  logic                        conflict;

  logic [NPORT-1:0]     ready_q, ready_d;
  logic [NPORT-1:0]     rd_q, rd_d;
  bank_id_t [NPORT-1:0] bank_q, bank_d;
  bank_id_t [NBANK-1:0] rr_q, rr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  // A port whose ready is high this cycle still holds valid; mask it out.
  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      pbank[p] = bank_sel(loc.loc_addr[p]);
      elig[p]  = loc.loc_valid[p] & ~ready_q[p];
    end
  end

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    logic [NPORT-1:0] g;
    logic             en;
    bank_id_t         idx;
    logic [RW-1:0]    row;
    logic [31:0]      wdata;
    logic [3:0]       wstrb;

    // Scan ports cyclically from the pointer; the first eligible hit wins.
    always_comb begin
      g     = '0;
      en    = 1'b0;
      idx   = '0;
      row   = '0;
      wdata = '0;
      wstrb = '0;
      for (int off = 0; off < NPORT; off++) begin
        idx = rr_q[b] + bank_id_t'(off);
        if (!en && elig[idx] && pbank[idx] == bank_id_t'(b)) begin
          en     = 1'b1;
          g[idx] = 1'b1;
          row    = RW'(row_sel(loc.loc_addr[idx]));
          wdata  = loc.loc_wdata[idx];
          wstrb  = loc.loc_wstrb[idx];
        end
      end
    end

    assign gnt_b[b] = g;

    rvr32_locmem_bank #(.RW(RW)) u_bank (
      .clk   (clk),
      .en    (en & ~rst),
      .row   (row),
      .wdata (wdata),
      .wstrb (wstrb),
      .rdata (bank_rdata[b])
    );
  end

  always_comb begin
    gnt = '0;
    for (int b = 0; b < NBANK; b++) begin
      gnt = gnt | gnt_b[b];
    end
  end

  always_comb begin
    ready_d  = gnt;
    conflict = |(elig & ~gnt);
    for (int p = 0; p < NPORT; p++) begin
      rd_d[p]   = is_read(loc.loc_wstrb[p]);
      bank_d[p] = pbank[p];
    end
    for (int b = 0; b < NBANK; b++) begin
      rr_d[b] = rr_q[b];
      for (int p = 0; p < NPORT; p++) begin
        if (gnt_b[b][p]) begin
          rr_d[b] = bank_id_t'(p + 1);
        end
      end
    end
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (conflict && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Grant edge: completion pulse and arbitration state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      ready_q <= ready_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Response steering is only consumed while ready_q is set.
  always_ff @(posedge clk) begin
    rd_q   <= rd_d;
    bank_q <= bank_d;
  end

  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      loc.loc_rdata[p] = (ready_q[p] && rd_q[p]) ? bank_rdata[bank_q[p]] : 32'h0;
    end
  end

  assign loc.loc_ready  = ready_q;
  assign conflict_cnt   = cnt_q;

endmodule
